// File: rtl/conv_window_gen.sv
// conv_window_gen: streams raster pixels through two line buffers and emits
// every fully-interior 3x3 window, with valid/ready on both sides.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic signed [7:0] pix_i,
    input  logic              pix_sof_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic signed [7:0] win_0_o,
    output logic signed [7:0] win_1_o,
    output logic signed [7:0] win_2_o,
    output logic signed [7:0] win_3_o,
    output logic signed [7:0] win_4_o,
    output logic signed [7:0] win_5_o,
    output logic signed [7:0] win_6_o,
    output logic signed [7:0] win_7_o,
    output logic signed [7:0] win_8_o,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic              frame_done_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col;
    logic [RW-1:0] row_q, row;
    logic signed [7:0] lb0 [IMG_W];
    logic signed [7:0] lb1 [IMG_W];
    logic signed [7:0] w [9];
    logic accept, qual, col_end, row_end;

    assign pix_ready_o = !win_valid_o || win_ready_i;
    assign accept      = pix_valid_i && pix_ready_o;
    // A start-of-frame pixel is always (0,0), whatever the counters say
    assign col         = pix_sof_i ? '0 : col_q;
    assign row         = pix_sof_i ? '0 : row_q;
    assign col_end     = col == CW'(IMG_W - 1);
    assign row_end     = row == RW'(IMG_H - 1);
    assign qual        = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            for (int i = 0; i < 9; i++) w[i] <= '0;
        end else if (accept) begin
            col_q        <= col_end ? '0 : col + 1'b1;
            row_q        <= col_end ? (row_end ? '0 : row + 1'b1) : row;
            w[0]         <= w[1];
            w[1]         <= w[2];
            w[2]         <= lb1[col];
            w[3]         <= w[4];
            w[4]         <= w[5];
            w[5]         <= lb0[col];
            w[6]         <= w[7];
            w[7]         <= w[8];
            w[8]         <= pix_i;
            win_valid_o  <= qual;
            frame_done_o <= qual && col_end && row_end;
        end else if (win_ready_i) begin
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end
    end

    // Line buffers carry no reset; the counters guarantee rows are rewritten before use
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_i;
        end
    end

    assign win_0_o = w[0];
    assign win_1_o = w[1];
    assign win_2_o = w[2];
    assign win_3_o = w[3];
    assign win_4_o = w[4];
    assign win_5_o = w[5];
    assign win_6_o = w[6];
    assign win_7_o = w[7];
    assign win_8_o = w[8];
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed scenario tests for conv_window_gen on a 4x4 frame.
module tb_conv_window_gen;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic signed [7:0] pix_i = '0;
    logic pix_sof_i = 1'b0, pix_valid_i = 1'b0, win_ready_i = 1'b1;
    logic pix_ready_o, win_valid_o, frame_done_o;
    logic signed [7:0] win_0_o, win_1_o, win_2_o, win_3_o, win_4_o, win_5_o, win_6_o, win_7_o, win_8_o;

    conv_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .pix_i(pix_i), .pix_sof_i(pix_sof_i),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .win_0_o(win_0_o), .win_1_o(win_1_o), .win_2_o(win_2_o),
        .win_3_o(win_3_o), .win_4_o(win_4_o), .win_5_o(win_5_o),
        .win_6_o(win_6_o), .win_7_o(win_7_o), .win_8_o(win_8_o),
        .win_valid_o(win_valid_o), .win_ready_i(win_ready_i), .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int fd_cycles = 0;
    logic [71:0] wq[$];
    logic fq[$];
    logic [71:0] exp_w [4] = '{
        72'h00_01_02_04_05_06_08_09_0a,
        72'h01_02_03_05_06_07_09_0a_0b,
        72'h04_05_06_08_09_0a_0c_0d_0e,
        72'h05_06_07_09_0a_0b_0d_0e_0f
    };
    wire [71:0] taps = {win_0_o, win_1_o, win_2_o, win_3_o, win_4_o, win_5_o, win_6_o, win_7_o, win_8_o};

    // Record each window at the negedge before the edge that completes its handshake
    always @(negedge clk_i) begin
        if (rst_n) begin
            if (win_valid_o && win_ready_i) begin
                wq.push_back(taps);
                fq.push_back(frame_done_o);
            end
            if (frame_done_o) fd_cycles++;
        end
    end

    task automatic clear_mon();
        wq.delete();
        fq.delete();
        fd_cycles = 0;
    endtask

    task automatic send(input logic [7:0] v, input logic sof);
        int n = 0;
        logic acc;
        pix_i = v;
        pix_sof_i = sof;
        pix_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            acc = pix_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixel %0d not accepted within 50 cycles", v);
        end
    endtask

    task automatic idle(input int n);
        pix_valid_i = 1'b0;
        pix_sof_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i == 0);
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", win_valid_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done_o); end
        checks++; if (taps !== 72'h0) begin errors++; $display("FAIL reset_taps got %h exp 0", taps); end
        checks++; if (pix_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", pix_ready_o); end
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_stream();
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i == 0);
            if (i == 9) begin
                checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", win_valid_o); end
            end
            if (i == 10) begin
                checks++; if (win_valid_o !== 1'b1) begin errors++; $display("FAIL stream_latency got %b exp 1", win_valid_o); end
                checks++; if (taps !== exp_w[0]) begin errors++; $display("FAIL stream_first got %h exp %h", taps, exp_w[0]); end
            end
        end
        idle(4);
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL stream_count got %0d exp 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL stream_win%0d got %h exp %h", i, wq[i], exp_w[i]); end
            checks++; if (fq[i] !== (i == 3)) begin errors++; $display("FAIL stream_fd%0d got %b exp %b", i, fq[i], i == 3); end
        end
        checks++; if (fd_cycles != 1) begin errors++; $display("FAIL stream_fd_pulse got %0d exp 1", fd_cycles); end
    endtask

    task automatic test_two_frames(input bit gaps);
        clear_mon();
        send_frame(gaps);
        send_frame(gaps);
        idle(4);
        checks++; if (wq.size() != 8) begin errors++; $display("FAIL frames%0d_count got %0d exp 8", gaps, wq.size()); end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            checks++; if (wq[i] !== exp_w[i % 4]) begin errors++; $display("FAIL frames%0d_win%0d got %h exp %h", gaps, i, wq[i], exp_w[i % 4]); end
            checks++; if (fq[i] !== (i % 4 == 3)) begin errors++; $display("FAIL frames%0d_fd%0d got %b exp %b", gaps, i, fq[i], i % 4 == 3); end
        end
        checks++; if (fd_cycles != 2) begin errors++; $display("FAIL frames%0d_fd_pulses got %0d exp 2", gaps, fd_cycles); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        for (int i = 0; i < 11; i++) send(8'(i), i == 0);
        win_ready_i = 1'b0;
        pix_i = 8'd11;
        pix_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            checks++; if (pix_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", pix_ready_o); end
            checks++; if (win_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", win_valid_o); end
            checks++; if (taps !== exp_w[0]) begin errors++; $display("FAIL bp_hold got %h exp %h", taps, exp_w[0]); end
        end
        @(posedge clk_i);
        #1;
        win_ready_i = 1'b1;
        for (int i = 11; i < 16; i++) send(8'(i), 1'b0);
        idle(4);
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL bp_win%0d got %h exp %h", i, wq[i], exp_w[i]); end
        end
    endtask

    task automatic test_sof_mid();
        clear_mon();
        for (int i = 0; i < 6; i++) send(8'(100 + i), i == 0);
        for (int i = 0; i < 16; i++) send(8'(i), i == 0);
        idle(4);
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL sof_count got %0d exp 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL sof_win%0d got %h exp %h", i, wq[i], exp_w[i]); end
        end
        checks++; if (fd_cycles != 1) begin errors++; $display("FAIL sof_fd_pulse got %0d exp 1", fd_cycles); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int i = 0; i < 12; i++) send(8'(i), i == 0);
        win_ready_i = 1'b0;
        pix_valid_i = 1'b0;
        pix_sof_i = 1'b0;
        checks++; if (win_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %b exp 1", win_valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (win_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", win_valid_o); end
        checks++; if (taps !== 72'h0) begin errors++; $display("FAIL rstmid_taps got %h exp 0", taps); end
        checks++; if (pix_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", pix_ready_o); end
        @(negedge clk_i);
        rst_n = 1'b1;
        win_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_mon();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        idle(4);
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL rstmid_count got %0d exp 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL rstmid_win%0d got %h exp %h", i, wq[i], exp_w[i]); end
        end
        checks++; if (fd_cycles != 1) begin errors++; $display("FAIL rstmid_fd_pulse got %0d exp 1", fd_cycles); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_two_frames(1'b0);
        test_backpressure();
        test_two_frames(1'b1);
        test_sof_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The block SHALL have parameter IMG_W, default 16, meaning pixels per image row (minimum 3).
REQ-002 The block SHALL have parameter IMG_H, default 16, meaning rows per frame (minimum 3).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert and active-low; no other reset exists.
REQ-005 The block SHALL have port pix_i  input  8  signed pixel, raster order (row-major, column 0 first).
REQ-006 The block SHALL have port pix_sof_i  input  1  start-of-frame flag, qualified by pix_valid_i.
REQ-007 The block SHALL have port pix_valid_i  input  1  pixel valid.
REQ-008 The block SHALL have port pix_ready_o  output  1  pixel accepted when pix_valid_i && pix_ready_o.
REQ-009 The block SHALL have ports win_0_o .. win_8_o  output  8 each  signed 3x3 window taps, row-major, with win_0_o at the top-left and win_8_o at the bottom-right.
REQ-010 The block SHALL have port win_valid_o  output  1  window valid.
REQ-011 The block SHALL have port win_ready_i  input  1  downstream conv engine accepts the window when win_valid_o && win_ready_i.
REQ-012 The block SHALL have port frame_done_o  output  1  one-cycle pulse marking the last window of a frame.

Function
REQ-013 The block SHALL maintain a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), both advancing only on an accepted pixel.
REQ-014 On acceptance, the column counter SHALL wrap from IMG_W-1 to 0 and increment the row counter; the row counter SHALL wrap from IMG_H-1 to 0.
REQ-015 An accepted pixel with pix_sof_i=1 SHALL be treated as (row 0, col 0) regardless of counter state, and the counters SHALL continue from there.
REQ-016 The block SHALL store the two previous rows in two IMG_W-deep line buffers, with a 3x3 shift-register window fed by column (line buffer 1, line buffer 0, new pixel).
REQ-017 Accepting pixel (r,c) with r>=2 and c>=2 SHALL assert win_valid_o on the next cycle, with taps equal to pixels (r-2..r, c-2..c).
REQ-018 Accepted pixels with r<2 or c<2 SHALL update the buffers but SHALL NOT produce a window.
REQ-019 Each frame SHALL therefore produce exactly (IMG_W-2)*(IMG_H-2) windows, with no padding.
REQ-020 pix_ready_o SHALL equal (!win_valid_o || win_ready_i), combinationally.
REQ-021 While win_valid_o=1 and win_ready_i=0, all win_*_o and frame_done_o SHALL hold stable and no pixel SHALL be accepted.
REQ-022 A handshake completing on a cycle with no new qualifying pixel SHALL deassert win_valid_o on the next cycle.
REQ-023 A handshake completing on the same cycle a qualifying pixel is accepted SHALL keep win_valid_o=1 and load the new window (back-to-back, one window per cycle).
REQ-024 frame_done_o SHALL be asserted together with win_valid_o for the window of pixel (IMG_H-1, IMG_W-1), and SHALL be cleared when that window is accepted.
REQ-025 Line buffers SHALL NOT be cleared between frames; stale contents SHALL never reach an emitted window.
REQ-026 Gaps in pix_valid_i SHALL NOT alter any state other than the handshake signals.
REQ-027 Latency from pixel acceptance to window valid SHALL be 1 cycle.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force win_valid_o=0, frame_done_o=0, all win_*_o=0, and both counters to 0; pix_ready_o SHALL be 1.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame, and the first pixel accepted after release SHALL be (0,0).
REQ-030 Line buffer contents SHALL be don't-care after reset.

Verification (IMG_W=4, IMG_H=4; pixel value = raster index 0..15; win_ready_i=1 unless stated)
REQ-031 Stream 0..15 with sof on 0 -> the first win_valid_o appears the cycle after pixel 10 with taps 0,1,2,4,5,6,8,9,10; 4 windows total (after pixels 10, 11, 14, 15).
REQ-032 Same stream -> the last window is 5,6,7,9,10,11,13,14,15 with frame_done_o=1 for one cycle; two consecutive frames produce 8 windows and 2 frame_done pulses.
REQ-033 Hold win_ready_i=0 for 5 cycles after the first window -> pix_ready_o=0, taps stay 0,1,2,4,5,6,8,9,10 unchanged; on release the next window is 1,2,3,5,6,7,9,10,11.
REQ-034 Random pix_valid_i gaps (about 50%) -> window sequence identical to REQ-031 and REQ-032.
REQ-035 Assert pix_sof_i on pixel index 6 mid-frame, then stream 16 pixels -> counting restarts, exactly 4 windows follow, and the first window covers relative pixels 0,1,2,4,5,6,8,9,10.
REQ-036 Pulse rst_n low after pixel 11 while a window is pending -> win_valid_o drops asynchronously; a fresh 16-pixel frame yields the REQ-031 results exactly.
